// File: rtl/mips_pkg.sv
// Shared definitions for the pipeline hazard unit: forwarding-mux encodings,
// memory-wait FSM state encodings and the register-match helper.
package mips_pkg;

    // Forwarding source select for the EXECUTE operand muxes
    localparam logic [1:0] FWD_RF  = 2'b00;  // value read from the register file
    localparam logic [1:0] FWD_WB  = 2'b01;  // value from the WRITEBACK stage
    localparam logic [1:0] FWD_MEM = 2'b10;  // value from the MEMORY stage

    // Memory-wait supervisor states
    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_ERR      = 2'b10
    } hz_state_t;

    // A producer matches a consumer only for a real register; $0 never matches
    function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src);
        return (dst != 5'd0) && (dst == src);
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Single-operand forwarding select for EXECUTE: MEMORY beats WRITEBACK,
// register file otherwise.
module hazard_fwd_sel
    import mips_pkg::*;
(
    input  logic [4:0] src,
    input  logic       wr_m,
    input  logic [4:0] dst_m,
    input  logic       wr_w,
    input  logic [4:0] dst_w,
    output logic [1:0] fwd
);

    // Priority compare: the younger (MEMORY) result shadows the older one
    always_comb begin
        fwd = FWD_RF;
        if (wr_m && reg_match(dst_m, src)) begin
            fwd = FWD_MEM;
        end else if (wr_w && reg_match(dst_w, src)) begin
            fwd = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: operand forwarding, load-use / branch stalls, decode
// flush on redirects, and a memory-wait supervisor that freezes the pipe and
// raises a sticky bus error after MEM_TIMEOUT wait cycles.
// Optional build macro HAZARD_PERF_EN adds stall_cnt / flush_cnt counters.
module hazard_unit
    import mips_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rsD,
    input  logic [4:0]       rtD,
    input  logic [4:0]       rsE,
    input  logic [4:0]       rtE,
    input  logic [4:0]       dstE,
    input  logic [4:0]       dstM,
    input  logic [4:0]       dstW,
    input  logic             wriSigEXEC,
    input  logic             wriSigMEMO,
    input  logic             wriSigWRIT,
    input  logic             wriRegFromMemEXEC,
    input  logic             wriRegFromMemMEMO,
    input  logic             wriMemorySigMEMO,
    input  logic             branchD,
    input  logic             jrD,
    input  logic             takenD,
    input  logic             mem_ready,
    output logic             stall,
    output logic             freeze,
    output logic             flushD,
    output logic [1:0]       fwdAE,
    output logic [1:0]       fwdBE,
    output logic             fwdAD,
    output logic             fwdBD,
    output logic             bus_err
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_V   = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W:0]   TIMEOUT_EXT = (WAIT_W + 1)'(MEM_TIMEOUT);

    hz_state_t         state_reg;
    logic [WAIT_W-1:0] wait_cnt_reg;
    logic [WAIT_W-1:0] wait_cnt_next;
    logic [WAIT_W:0]   wait_inc;
    logic              timeout_hit;
    logic              bus_err_reg;
    logic              mem_req;
    logic              lwstall;
    logic              brstall;
    logic              dec_uses_e;
    logic              dec_uses_m;

    // ---------------- EXECUTE forwarding: one selector per operand ----------
    logic [4:0] src_e [2];
    logic [1:0] fwd_e [2];

    assign src_e[0] = rsE;
    assign src_e[1] = rtE;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            hazard_fwd_sel u_fwd_sel (
                .src   (src_e[gi]),
                .wr_m  (wriSigMEMO),
                .dst_m (dstM),
                .wr_w  (wriSigWRIT),
                .dst_w (dstW),
                .fwd   (fwd_e[gi])
            );
        end
    endgenerate

    assign fwdAE = fwd_e[0];
    assign fwdBE = fwd_e[1];

    // DECODE forwarding (branch compare) only from MEMORY
    assign fwdAD = wriSigMEMO && reg_match(dstM, rsD);
    assign fwdBD = wriSigMEMO && reg_match(dstM, rtD);

    // ---------------- stalls and flush ---------------------------------------
    assign dec_uses_e = reg_match(dstE, rsD) || reg_match(dstE, rtD);
    assign dec_uses_m = reg_match(dstM, rsD) || reg_match(dstM, rtD);

    assign lwstall = wriRegFromMemEXEC && dec_uses_e;
    assign brstall = (branchD || jrD) &&
                     ((wriSigEXEC && dec_uses_e) || (wriRegFromMemMEMO && dec_uses_m));

    // A frozen pipe holds everything, so a stall would be redundant
    assign stall  = (lwstall || brstall) && !freeze;
    assign flushD = takenD && !stall && !freeze;

    // ---------------- memory-wait supervisor ---------------------------------
    assign mem_req = wriMemorySigMEMO || wriRegFromMemMEMO;

    // Wait counter arithmetic computed one bit wider so saturation never wraps
    assign wait_inc      = {1'b0, wait_cnt_reg} + (WAIT_W + 1)'(1);
    assign timeout_hit   = (wait_inc >= TIMEOUT_EXT);
    assign wait_cnt_next = timeout_hit ? TIMEOUT_V : wait_inc[WAIT_W-1:0];

    // Freeze is combinational so the pipe holds in the very cycle the access stalls
    always_comb begin
        freeze = 1'b0;
        case (state_reg)
            ST_RUN:      freeze = mem_req && !mem_ready;
            ST_MEM_WAIT: freeze = !mem_ready;
            ST_ERR:      freeze = 1'b1;
            default:     freeze = 1'b0;
        endcase
    end

    // FSM: RUN -> MEM_WAIT on an unfinished access, back on mem_ready, ERR on timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_RUN;
            wait_cnt_reg <= '0;
            bus_err_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (mem_req && !mem_ready) begin
                        state_reg    <= ST_MEM_WAIT;
                        wait_cnt_reg <= '0;
                    end
                end
                ST_MEM_WAIT: begin
                    wait_cnt_reg <= wait_cnt_next;
                    if (mem_ready) begin
                        state_reg <= ST_RUN;
                    end else if (timeout_hit) begin
                        state_reg   <= ST_ERR;
                        bus_err_reg <= 1'b1;
                    end
                end
                ST_ERR: begin
                    bus_err_reg <= 1'b1;
                end
                default: begin
                    state_reg    <= ST_RUN;
                    wait_cnt_reg <= '0;
                    bus_err_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus_err = bus_err_reg;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] flush_cnt_reg;

    // Free-running event counters; wrap naturally at 2^CNT_W
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (stall) begin
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            end
            if (flushD) begin
                flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign flush_cnt = flush_cnt_reg;
`endif

endmodule
